// File: rtl/mtr_pkg.sv
// Shared types and constants for the motor drive back end.
// Speed-to-duty mapping lives here so every consumer agrees on it.
package mtr_pkg;

    localparam int PWM_W        = 11;
    localparam int SPD_W        = 12;
    localparam int DEAD_DEFAULT = 32;

    typedef logic [PWM_W-1:0] duty_t;
    typedef logic [SPD_W-1:0] spd_t;

    localparam duty_t MID_DUTY = 11'h400;
    localparam duty_t CNT_MAX  = 11'h7FF;

    // Offset-binary shift: full reverse maps to 0, stop to mid-scale.
    function automatic duty_t spd2duty(input spd_t spd);
        spd_t w_sum;
        w_sum = spd + 12'h800;
        return w_sum[SPD_W-1:1];
    endfunction

endpackage

// File: rtl/mtr_drv_pwm_nonoverlap.sv
// One wheel: raw PWM compare plus complementary gate pair with dead time.
// Any edge of the raw PWM blanks both gates for DEAD clocks.
module pwm_nonoverlap
    import mtr_pkg::*;
#(
    parameter int DEAD = DEAD_DEFAULT
) (
    input  logic  clk,
    input  logic  rst_n,
    input  duty_t i_cnt,
    input  duty_t i_duty_q,
    output logic  o_PWM1,
    output logic  o_PWM2
);

    localparam int DW = $clog2(DEAD + 1);
    localparam logic [DW-1:0] DEAD_MAX  = DW'(DEAD);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD - 1);

    logic          r_sig;
    logic          r_prev;
    logic [DW-1:0] r_dead;
    logic          r_pwm1;
    logic          r_pwm2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig  <= 1'b0;
            r_prev <= 1'b0;
            r_dead <= '0;
            r_pwm1 <= 1'b0;
            r_pwm2 <= 1'b0;
        end else begin
            r_sig  <= (i_cnt < i_duty_q);
            r_prev <= r_sig;
            if (r_sig != r_prev) begin
                r_dead <= '0;
                r_pwm1 <= 1'b0;
                r_pwm2 <= 1'b0;
            end else begin
                if (r_dead != DEAD_MAX)
                    r_dead <= r_dead + DW'(1);
                // Window expires: gates follow the settled raw PWM.
                if (r_dead == DEAD_LAST) begin
                    r_pwm1 <= r_sig;
                    r_pwm2 <= ~r_sig;
                end
            end
        end
    end

    assign o_PWM1 = r_pwm1;
    assign o_PWM2 = r_pwm2;

endmodule

// File: rtl/mtr_drv.sv
// Motor drive top: shared period counter, per-period duty capture,
// and one non-overlap gate pair per wheel.
module mtr_drv
    import mtr_pkg::*;
#(
    parameter int DEAD = DEAD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SPD_W-1:0] lft_spd,
    input  logic [SPD_W-1:0] rght_spd,
    output logic             lft_PWM1,
    output logic             lft_PWM2,
    output logic             rght_PWM1,
    output logic             rght_PWM2,
    output logic             PWM_synch
);

    duty_t r_cnt;
    duty_t r_lft_duty;
    duty_t r_rght_duty;
    logic  w_wrap;

    assign w_wrap = (r_cnt == CNT_MAX);

    // Duty only moves at the wrap so a period never sees two compares.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_lft_duty  <= MID_DUTY;
            r_rght_duty <= MID_DUTY;
        end else begin
            r_cnt <= r_cnt + duty_t'(1);
            if (w_wrap) begin
                r_lft_duty  <= spd2duty(lft_spd);
                r_rght_duty <= spd2duty(rght_spd);
            end
        end
    end

    assign PWM_synch = w_wrap;

    pwm_nonoverlap #(.DEAD(DEAD)) u_lft (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_cnt    (r_cnt),
        .i_duty_q (r_lft_duty),
        .o_PWM1   (lft_PWM1),
        .o_PWM2   (lft_PWM2)
    );

    pwm_nonoverlap #(.DEAD(DEAD)) u_rght (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_cnt    (r_cnt),
        .i_duty_q (r_rght_duty),
        .o_PWM1   (rght_PWM1),
        .o_PWM2   (rght_PWM2)
    );

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: directed period checks plus a randomized
// scoreboard of PWM1 pulse widths against a duty/dead-time model.
module tb_mtr_drv;

    localparam int DEAD   = 32;
    localparam int PERIOD = 2048;

    logic        clk;
    logic        rst_n;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        lft_PWM1;
    logic        lft_PWM2;
    logic        rght_PWM1;
    logic        rght_PWM2;
    logic        PWM_synch;

    int n_vec;
    int n_err;

    mtr_drv #(.DEAD(DEAD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .lft_PWM1  (lft_PWM1),
        .lft_PWM2  (lft_PWM2),
        .rght_PWM1 (rght_PWM1),
        .rght_PWM2 (rght_PWM2),
        .PWM_synch (PWM_synch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-window high-time accumulators, closed at each synch pulse.
    int acc_l1, acc_l2, acc_r1, acc_r2, acc_len;
    int w_l1, w_l2, w_r1, w_r2, w_len;

    initial begin
        acc_l1 = 0; acc_l2 = 0; acc_r1 = 0; acc_r2 = 0; acc_len = 0;
        w_l1 = 0; w_l2 = 0; w_r1 = 0; w_r2 = 0; w_len = 0;
    end

    always @(negedge clk) begin
        acc_l1  += int'(lft_PWM1);
        acc_l2  += int'(lft_PWM2);
        acc_r1  += int'(rght_PWM1);
        acc_r2  += int'(rght_PWM2);
        acc_len += 1;
        if (PWM_synch) begin
            w_l1 = acc_l1; w_l2 = acc_l2;
            w_r1 = acc_r1; w_r2 = acc_r2;
            w_len = acc_len;
            acc_l1 = 0; acc_l2 = 0; acc_r1 = 0; acc_r2 = 0; acc_len = 0;
        end
    end

    int  n_ovl;
    initial n_ovl = 0;

    always @(negedge clk) begin
        if ((lft_PWM1 && lft_PWM2) || (rght_PWM1 && rght_PWM2)) begin
            n_err++;
            n_ovl++;
            if (n_ovl < 10)
                $display("FAIL overlap at %0t: lft=%b%b rght=%b%b required never both high",
                         $time, lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2);
        end
    end

    // Scoreboard: expected PWM1 high-run lengths, one per period with a run.
    int q_l[$];
    int q_r[$];
    bit sb_on;
    int run_l, run_r;
    logic p_l, p_r;

    initial begin
        sb_on = 1'b0;
        run_l = 0; run_r = 0;
        p_l = 1'b0; p_r = 1'b0;
    end

    always @(negedge clk) begin
        int exp_v;
        if (sb_on && p_l && !lft_PWM1) begin
            n_vec++;
            if (q_l.size() == 0) begin
                n_err++;
                $display("FAIL lft_run: got %0d clocks, required no pulse", run_l);
            end else begin
                exp_v = q_l.pop_front();
                if (run_l != exp_v) begin
                    n_err++;
                    $display("FAIL lft_run: got %0d clocks, required %0d", run_l, exp_v);
                end
            end
        end
        if (sb_on && p_r && !rght_PWM1) begin
            n_vec++;
            if (q_r.size() == 0) begin
                n_err++;
                $display("FAIL rght_run: got %0d clocks, required no pulse", run_r);
            end else begin
                exp_v = q_r.pop_front();
                if (run_r != exp_v) begin
                    n_err++;
                    $display("FAIL rght_run: got %0d clocks, required %0d", run_r, exp_v);
                end
            end
        end
        run_l = lft_PWM1  ? run_l + 1 : 0;
        run_r = rght_PWM1 ? run_r + 1 : 0;
        p_l = lft_PWM1;
        p_r = rght_PWM1;
    end

    task automatic chk(input string name, input int got, input int exp_v);
        n_vec++;
        if (got != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp_v);
        end
    endtask

    task automatic wait_synch();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!PWM_synch && k < PERIOD + 60);
        if (!PWM_synch) begin
            n_err++;
            $display("FAIL synch_timeout: got no pulse in %0d clocks, required one", k);
        end
        #1;
    endtask

    // Model: signed speed s in -2048..2047 gives duty (s+2048)/2 out of 2048;
    // the high-side gate loses DEAD clocks of every raw pulse.
    function automatic int model_run(input logic [11:0] spd);
        int s;
        int d;
        s = int'($signed(spd));
        d = (s + 2048) / 2;
        return d - DEAD;
    endfunction

    function automatic logic [11:0] pick_spd();
        logic [11:0] v;
        case ($urandom_range(0, 5))
            0:       v = 12'h800;
            1:       v = 12'h7FF;
            2:       v = 12'h000;
            default: v = 12'($urandom_range(0, 4095));
        endcase
        return v;
    endfunction

    initial begin
        int bad;
        int hl;
        int hr;
        int e;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        lft_spd = 12'h000;
        rght_spd = 12'h000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_lft_PWM1", int'(lft_PWM1), 0);
        chk("rst_lft_PWM2", int'(lft_PWM2), 0);
        chk("rst_rght_PWM1", int'(rght_PWM1), 0);
        chk("rst_rght_PWM2", int'(rght_PWM2), 0);
        chk("rst_synch", int'(PWM_synch), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero speed: 50% duty on both wheels.
        wait_synch();
        for (int i = 0; i < 2; i++) begin
            wait_synch();
            chk("zero_period_len", w_len, PERIOD);
            chk("zero_lft_PWM1", w_l1, 992);
            chk("zero_lft_PWM2", w_l2, 992);
            chk("zero_rght_PWM1", w_r1, 992);
            chk("zero_rght_PWM2", w_r2, 992);
        end

        // Full forward: low pulse of one clock is swallowed.
        lft_spd = 12'h7FF;
        wait_synch();
        wait_synch();
        chk("fwd_lft_PWM1", w_l1, 2015);
        chk("fwd_lft_PWM2", w_l2, 0);
        chk("fwd_rght_PWM1", w_r1, 992);

        // Full reverse.
        lft_spd = 12'h800;
        wait_synch();
        wait_synch();
        chk("rev_lft_PWM1", w_l1, 0);
        chk("rev_lft_PWM2", w_l2, PERIOD);
        chk("rev_rght_PWM2", w_r2, 992);

        // Mid-period command change waits for the wrap.
        repeat (12'h201) @(posedge clk);
        #1;
        rght_spd = 12'h400;
        wait_synch();
        chk("mid_rght_PWM1_hold", w_r1, 992);
        chk("mid_rght_PWM2_hold", w_r2, 992);
        chk("mid_lft_PWM2", w_l2, PERIOD);
        wait_synch();
        chk("mid_rght_PWM1_new", w_r1, 1504);
        chk("mid_lft_PWM1", w_l1, 0);

        // Asynchronous reset in the middle of a high pulse.
        lft_spd = 12'h000;
        rght_spd = 12'h000;
        wait_synch();
        repeat (12'h124) @(posedge clk);
        #1;
        chk("pre_rst_lft_PWM1", int'(lft_PWM1), 1);
        chk("pre_rst_rght_PWM1", int'(rght_PWM1), 1);
        rst_n = 1'b0;
        #1;
        chk("async_lft_PWM1", int'(lft_PWM1), 0);
        chk("async_lft_PWM2", int'(lft_PWM2), 0);
        chk("async_rght_PWM1", int'(rght_PWM1), 0);
        chk("async_rght_PWM2", int'(rght_PWM2), 0);
        chk("async_synch", int'(PWM_synch), 0);
        rght_spd = 12'h400;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (DEAD) begin
            @(negedge clk);
            if (lft_PWM1 || lft_PWM2 || rght_PWM1 || rght_PWM2) bad++;
        end
        chk("rel_gap_high_clocks", bad, 0);
        hl = 0;
        hr = 0;
        repeat (1100) begin
            @(negedge clk);
            hl += int'(lft_PWM1);
            hr += int'(rght_PWM1);
        end
        chk("rel_lft_PWM1", hl, 992);
        chk("rel_rght_PWM1", hr, 992);
        wait_synch();

        // Park both wheels at duty 0, then randomize under the scoreboard.
        lft_spd = 12'h800;
        rght_spd = 12'h800;
        wait_synch();
        wait_synch();
        sb_on = 1'b1;
        for (int i = 0; i < 12; i++) begin
            lft_spd = pick_spd();
            rght_spd = pick_spd();
            e = model_run(lft_spd);
            if (e > 0) q_l.push_back(e);
            e = model_run(rght_spd);
            if (e > 0) q_r.push_back(e);
            wait_synch();
        end
        lft_spd = 12'h800;
        rght_spd = 12'h800;
        repeat (3) wait_synch();
        chk("lft_runs_left", q_l.size(), 0);
        chk("rght_runs_left", q_r.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
